cmd_dispatcher: RTL and testbench

Sits between the memory block and the peripheral interfaces (switch, ADC, DAC, timer, multiclock). It pops 32-bit command words, decodes {data[31:16], addr[15:8], op[7:4], dev[3:0]}, strobes exactly one device chip-select and waits for that device's ready. When the device returns a result, it pushes 16-bit result words into the output FIFO. A per-command timeout and sticky error status keep a hung peripheral from stalling the sequence.

---
 rtl/cmd_dispatcher_pkg.sv | 13 +
 rtl/cmd_dispatcher_result_serializer.sv | 28 ++
 rtl/cmd_dispatcher.sv | 133 +++++++++++++
 tb/tb_cmd_dispatcher.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cmd_dispatcher_pkg.sv
// cmd_dispatcher_pkg: device indices, op codes, error codes and FSM states shared by the dispatcher.
package cmd_dispatcher_pkg;
    localparam logic [3:0] DEV_SWITCH  = 4'd0;
    localparam logic [3:0] DEV_ADC     = 4'd1;
    localparam logic [3:0] DEV_DAC     = 4'd2;
    localparam logic [3:0] DEV_TIMER   = 4'd3;
    localparam logic [3:0] DEV_CLOCK   = 4'd4;
    localparam logic [3:0] OP_READ_DEF = 4'h1;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_DEV = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_ISSUE, ST_WAIT, ST_RESULT} state_t;
endpackage

// File: rtl/cmd_dispatcher_result_serializer.sv
// cmd_dispatcher_result_serializer: holds up to three 16-bit result words and shifts one out per accepted write.
module cmd_dispatcher_result_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [47:0] i_words,
    input  logic [1:0]  i_count,
    input  logic        i_shift,
    output logic [15:0] o_word,
    output logic        o_last
);
    logic [47:0] r_words;
    logic [1:0]  r_left;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_words <= '0;
            r_left  <= '0;
        end else if (i_load) begin
            r_words <= i_words;
            r_left  <= i_count;
        end else if (i_shift && r_left != 2'd0) begin
            r_words <= {16'h0, r_words[47:16]};
            r_left  <= r_left - 2'd1;
        end
    end
    assign o_word = r_words[15:0];
    assign o_last = (r_left == 2'd1);
endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: pops command words, strobes one device select, waits for ready with a timeout
// and streams any device result into the output FIFO.
module cmd_dispatcher
    import cmd_dispatcher_pkg::*;
#(
    parameter int         NDEV      = 5,
    parameter int         TIMEOUT_W = 16,
    parameter logic [3:0] OP_READ   = OP_READ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            cmd_valid,
    output logic            cmd_pop,
    input  logic [31:0]     cmd,
    output logic [3:0]      op,
    output logic [7:0]      addr,
    output logic [15:0]     data,
    output logic [NDEV-1:0] cs,
    input  logic [NDEV-1:0] rdy,
    input  logic [13:0]     adc_out,
    input  logic [47:0]     time_in,
    input  logic            res_full,
    output logic            res_we,
    output logic [15:0]     res_data,
    output logic            busy,
    output logic            err,
    output logic [1:0]      err_code
);
    state_t                 r_state;
    logic [3:0]             r_op;
    logic [7:0]             r_addr;
    logic [15:0]            r_data;
    logic [3:0]             r_dev;
    logic [NDEV-1:0]        r_cs;
    logic [NDEV-1:0]        r_sel;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic                   r_err;
    logic [1:0]             r_code;

    logic                   w_pop;
    logic                   w_dev_ok;
    logic                   w_done;
    logic [TIMEOUT_W-1:0]   w_cnt_nxt;
    logic [1:0]             w_nres;
    logic [47:0]            w_words;
    logic [15:0]            w_word;
    logic                   w_last;

    assign w_pop     = rst_n && r_state == ST_IDLE && en && cmd_valid;
    assign w_dev_ok  = {1'b0, r_dev} < 5'(NDEV);
    // A zero counter marks the first WAIT cycle, where ready is still stale from before the strobe.
    assign w_done    = r_cnt != '0 && |(rdy & r_sel);
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_nres    = (r_dev == DEV_ADC) ? 2'd1 : (r_dev == DEV_CLOCK && r_op == OP_READ) ? 2'd3 : 2'd0;
    assign w_words   = (r_dev == DEV_ADC) ? {34'h0, adc_out} : time_in;

    cmd_dispatcher_result_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (r_state == ST_WAIT && w_done && w_nres != 2'd0),
        .i_words (w_words),
        .i_count (w_nres),
        .i_shift (res_we),
        .o_word  (w_word),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_dev   <= '0;
            r_cs    <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            r_cs <= '0;
            case (r_state)
                ST_IDLE: if (w_pop) begin
                    r_op    <= cmd[7:4];
                    r_addr  <= cmd[15:8];
                    r_data  <= cmd[31:16];
                    r_dev   <= cmd[3:0];
                    r_state <= ST_DECODE;
                end
                ST_DECODE: if (!w_dev_ok) begin
                    if (!r_err) begin
                        r_err  <= 1'b1;
                        r_code <= ERR_BAD_DEV;
                    end
                    r_state <= ST_IDLE;
                end else begin
                    r_cs    <= NDEV'(1) << r_dev;
                    r_sel   <= NDEV'(1) << r_dev;
                    r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: if (w_done) begin
                    r_state <= (w_nres != 2'd0) ? ST_RESULT : ST_IDLE;
                end else if (&w_cnt_nxt) begin
                    if (!r_err) begin
                        r_err  <= 1'b1;
                        r_code <= ERR_TIMEOUT;
                    end
                    r_state <= ST_IDLE;
                end else begin
                    r_cnt <= w_cnt_nxt;
                end
                ST_RESULT: if (res_we && w_last) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_pop  = w_pop;
    assign op       = r_op;
    assign addr     = r_addr;
    assign data     = r_data;
    assign cs       = r_cs;
    assign res_we   = r_state == ST_RESULT && !res_full;
    assign res_data = w_word;
    assign busy     = r_state != ST_IDLE;
    assign err      = r_err;
    assign err_code = r_code;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: directed and randomized commands against a per-command reference model of the dispatcher.
module tb_cmd_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n, en, cmd_valid, cmd_pop;
    logic [31:0] cmd;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [4:0]  cs, rdy;
    logic [13:0] adc_out;
    logic [47:0] time_in;
    logic        res_full, res_we, busy, err;
    logic [15:0] res_data;
    logic [1:0]  err_code;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_err = 1'b0;
    logic [1:0]  m_code = 2'd0;
    logic [15:0] got_q[$];
    int          we_full_cnt = 0;

    always #5 clk = ~clk;

    cmd_dispatcher #(.NDEV(5), .TIMEOUT_W(4), .OP_READ(4'h1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmd_valid(cmd_valid), .cmd_pop(cmd_pop), .cmd(cmd),
        .op(op), .addr(addr), .data(data), .cs(cs), .rdy(rdy), .adc_out(adc_out), .time_in(time_in),
        .res_full(res_full), .res_we(res_we), .res_data(res_data), .busy(busy), .err(err), .err_code(err_code)
    );

    always @(negedge clk) if (res_we) begin
        got_q.push_back(res_data);
        if (res_full) we_full_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one command to completion; d = cycles after the strobe before the device raises ready.
    task automatic run_cmd(input logic [31:0] c, input int d, input bit hang, input bit stall,
                           input logic [13:0] av, input logic [47:0] tv);
        int dev = int'(c[3:0]);
        int t = 0, pop_t = -1, cs_t = -1, end_t = -1, ncs = 0;
        logic [4:0]  cs_v = '0;
        logic [15:0] exp_q[$];
        if (dev == 1) exp_q.push_back({2'b00, av});
        if (dev == 4 && c[7:4] == 4'h1) begin
            exp_q.push_back(tv[15:0]);
            exp_q.push_back(tv[31:16]);
            exp_q.push_back(tv[47:32]);
        end
        if (hang || dev >= 5) exp_q.delete();
        if (!m_err && dev >= 5) begin m_err = 1'b1; m_code = 2'd1; end
        if (!m_err && hang) begin m_err = 1'b1; m_code = 2'd2; end
        got_q.delete();
        we_full_cnt = 0;
        adc_out = av;
        time_in = tv;
        rdy = '1;
        while (end_t < 0 && t < 60) begin
            @(posedge clk); #1;
            en = 1'b1;
            cmd = c;
            cmd_valid = (pop_t < 0);
            res_full = stall && ($urandom_range(0, 2) == 0);
            if (cs_t >= 0 && !hang && t == cs_t + d) rdy[dev] = 1'b1;
            if (cs_t >= 0 && t == cs_t + d + 2) begin
                adc_out = 14'($urandom);
                time_in = 48'({$urandom, $urandom});
            end
            @(negedge clk);
            if (cmd_pop && pop_t < 0) pop_t = t;
            if (cs != '0) begin
                ncs++;
                cs_v = cs;
                cs_t = t;
                if (dev < 5) rdy[dev] = 1'b0;
            end
            if (pop_t >= 0 && t > pop_t && !busy) end_t = t;
            t++;
        end
        rdy = '1;
        res_full = 1'b0;
        check("done", 64'(end_t >= 0), 64'd1);
        check("pop_at", 64'(pop_t), 64'd0);
        check("cs_cnt", 64'(ncs), (dev < 5) ? 64'd1 : 64'd0);
        if (dev < 5) begin
            check("cs_val", 64'(cs_v), 64'(5'd1 << dev));
            check("cs_lat", 64'(cs_t - pop_t), 64'd2);
        end
        if (hang) check("tmo_len", 64'(end_t - cs_t), 64'd16);
        check("op", 64'(op), 64'(c[7:4]));
        check("addr", 64'(addr), 64'(c[15:8]));
        check("data", 64'(data), 64'(c[31:16]));
        check("nres", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("res_word", 64'(got_q[i]), 64'(exp_q[i]));
        check("we_full", 64'(we_full_cnt), 64'd0);
        check("err", 64'(err), 64'(m_err));
        check("err_code", 64'(err_code), 64'(m_code));
    endtask

    initial begin
        int pops;
        rst_n = 1'b0; en = 1'b0; cmd_valid = 1'b0; cmd = '0; rdy = '1;
        adc_out = '0; time_in = '0; res_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cs", 64'(cs), 64'd0);
        check("rst_err", 64'({err, err_code}), 64'd0);
        check("rst_fields", 64'({op, addr, data}), 64'd0);
        check("rst_we", 64'({res_we, cmd_pop}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_cmd(32'h0ABC_0302, 3, 1'b0, 1'b0, 14'h0, 48'h0);
        run_cmd(32'h0000_0001, 2, 1'b0, 1'b0, 14'h02F1, 48'h0);
        run_cmd(32'h0000_0014, 2, 1'b0, 1'b1, 14'h0, 48'h0000_1234_5678);
        run_cmd(32'h0000_0007, 1, 1'b0, 1'b0, 14'h0, 48'h0);
        run_cmd(32'h1111_2202, 1, 1'b0, 1'b0, 14'h0, 48'h0);

        // Reset in the middle of a WAIT must abort the command with nothing written.
        @(posedge clk); #1;
        en = 1'b1; cmd = 32'h5555_6610; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; rdy[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0; en = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cs", 64'(cs), 64'd0);
        check("mid_rst_err", 64'({err, err_code}), 64'd0);
        check("mid_rst_fields", 64'({op, addr, data}), 64'd0);
        check("mid_rst_we", 64'({res_we, cmd_pop}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cmd_pop || busy) pops++;
        end
        check("en_low_pop", 64'(pops), 64'd0);
        cmd_valid = 1'b0; rdy = '1;
        m_err = 1'b0; m_code = 2'd0;

        run_cmd(32'h0000_0000, 1, 1'b1, 1'b0, 14'h0, 48'h0);
        run_cmd(32'h0000_0009, 1, 1'b0, 1'b0, 14'h0, 48'h0);
        run_cmd(32'h0000_0003, 2, 1'b0, 1'b0, 14'h0, 48'h0);

        for (int k = 0; k < 40; k++) begin
            int dv = int'($urandom_range(0, 9));
            int ov = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 15));
            if (dv > 7) dv = 4;
            run_cmd({16'($urandom), 8'($urandom), 4'(ov), 4'(dv)}, int'($urandom_range(1, 6)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                    14'($urandom), 48'({$urandom, $urandom}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
